spi_slave_sync: RTL and testbench
=================================

// Module: spi_slave_sync
// PURPOSE
//  Synchronous SPI responder (slave) for the SPI_MASTER frame format: LOAD low frames a transfer, MSB first.
//  Samples SCLK/LOAD/MOSI in the system clock domain, deserialises MOSI into rx_data and serialises tx_data onto MISO.
//  Replaces the SCLK-clocked slave for on-chip integration: all state runs on clk.
//  Host side: tx_data captured at frame start; rx_data delivered with a one-cycle rx_valid strobe.
// PARAMETERS
//  DATA_W   9   frame length in bits (matches master word width)
//  SYNC_N   2   synchroniser depth for SCLK, LOAD, MOSI (>=2)
// PORTS
//  clk       in   1       system clock; SCLK frequency <= clk/8
//  rst       in   1       synchronous, active-high reset
//  SCLK      in   1       SPI clock from master, idle low
//  LOAD      in   1       frame select from master, active low; high = idle
//  MOSI      in   1       master-out data, valid at SCLK rising edge
//  MISO      out  1       slave-out data, changes after SCLK falling edge
//  tx_data   in   DATA_W  word to send; captured on LOAD falling edge
//  tx_ack    out  1       1-cycle pulse: tx_data captured, host may update it
//  rx_data   out  DATA_W  last complete received word; held until next frame completes
//  rx_valid  out  1       1-cycle pulse: rx_data updated
//  busy      out  1       high while a frame is in progress
// BEHAVIOUR
//  Reset: state=IDLE, shift regs=0, bit_cnt=0, MISO=0, rx_data=0, rx_valid=0, tx_ack=0, busy=0.
//  Inputs pass SYNC_N flops; edges detected on synchronised copies (1 extra flop) -> fixed 3-clk input latency.
//  FSM IDLE -> SHIFT on LOAD fall: tx_sr<=tx_data, MISO<=tx_data[DATA_W-1], bit_cnt<=0, tx_ack=1, busy=1.
//  SHIFT, SCLK rise: rx_sr<={rx_sr[DATA_W-2:0],MOSI_s}; bit_cnt<=bit_cnt+1 (saturates at DATA_W).
//  SHIFT, SCLK fall: tx_sr<<=1, MISO<=next bit; after last bit MISO holds 0.
//  SHIFT -> DONE on LOAD rise. DONE (1 clk): if bit_cnt==DATA_W then rx_data<=rx_sr, rx_valid=1; -> IDLE, busy=0.
//  Short frame (LOAD rises early): rx_data unchanged, no rx_valid. Long frame: extra bits shifted, last DATA_W kept.
//  SCLK edges while LOAD high are ignored. LOAD fall in DONE: handled in the next IDLE cycle (not lost, latency +1).
//  LOAD rise and SCLK edge on the same synchronised cycle: SCLK edge applied first, then frame ends.
//  rst mid-frame: immediate return to reset values; remainder of that frame ignored until LOAD returns high.
//  bit_cnt width = $clog2(DATA_W+1); no wrap.
// CONFIGURATION
//  SPI_SLV_FRAME_ERR_EN defined: adds output frame_err (1 bit), 1-clk pulse in DONE when bit_cnt != DATA_W
//   (short frame or SCLK count > DATA_W, tracked via sticky overflow bit); rx_data still updated only on exact count.
//  Undefined: no frame_err port, no overflow bit; behaviour otherwise identical.
// STRUCTURE
//  spi_defs.vh: default DATA_W, FSM state encodings (IDLE/SHIFT/DONE, 2 bits), SCLK:clk ratio limit.
//  Sub-module spi_sync: SYNC_N-deep synchroniser + rise/fall edge pulses, instantiated for SCLK and LOAD;
//   MOSI uses the same chain without edge outputs.
// TESTING
//  Bench drives SCLK = clk/8 behavioural master; checks against reference model.
//  1 Reset, then frame MOSI=9'b101111010, tx_data=9'b111011011 -> MISO bits 1,1,1,0,1,1,0,1,1; rx_data=9'h17A, one rx_valid.
//  2 tx_ack pulses once per frame; tx_data changed mid-frame -> MISO sequence unaffected.
//  3 Short frame, 5 SCLKs -> no rx_valid, rx_data keeps previous; with SPI_SLV_FRAME_ERR_EN frame_err=1.
//  4 Back-to-back frames, LOAD high 1 SCLK period -> two rx_valid, both words correct.
//  5 rst asserted after bit 4 -> all outputs at reset values next clk; next full frame received correctly.
//  6 SCLK toggling with LOAD high -> no state change, MISO=0, busy=0.

Source files
------------

// File: rtl/spi_slave_sync_pkg.sv
// Shared definitions for the clk-domain SPI responder: default sizes,
// FSM state encoding and the counter-width helper.
package spi_slave_sync_pkg;

  // Default frame length, matching the SPI master word width.
  localparam int DATA_W_DEF   = 9;
  // Default synchroniser depth for the SPI pins (must be >= 2).
  localparam int SYNC_N_DEF   = 2;
  // SCLK must run at clk/SCLK_DIV_MIN or slower so every SCLK phase
  // survives the synchroniser plus edge-detect latency.
  localparam int SCLK_DIV_MIN = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Width needed to count 0..n inclusive without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// SPI pin bundle plus host-side word interface of spi_slave_sync.
// Optional macro SPI_SLV_FRAME_ERR_EN adds the frame_err strobe.
interface spi_slave_sync_if
  import spi_slave_sync_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              SCLK;
  logic              LOAD;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic              frame_err;
`endif

  // Responder view: SPI pins and tx_data in, everything else out.
  modport slave (
    input  SCLK, LOAD, MOSI, tx_data,
    output MISO, tx_ack, rx_data, rx_valid, busy
`ifdef SPI_SLV_FRAME_ERR_EN
    , output frame_err
`endif
  );

  // Master/host view: drives the pins and tx_data, observes the rest.
  modport master (
    output SCLK, LOAD, MOSI, tx_data,
    input  MISO, tx_ack, rx_data, rx_valid, busy
`ifdef SPI_SLV_FRAME_ERR_EN
    , input frame_err
`endif
  );

endinterface

// File: rtl/spi_slave_sync_sync.sv
// Multi-bit SYNC_N-deep synchroniser. The low E bits additionally get
// rise/fall pulses from one extra history flop; upper bits are level only.
// The chain is deliberately not reset so it always mirrors the pins and a
// reset never fabricates an edge out of a pin that is held low.
module spi_slave_sync_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int SYNC_N = SYNC_N_DEF,
  parameter int W      = 3,
  parameter int E      = 2
) (
  input  logic         clk,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] lvl_o,
  output logic [E-1:0] rise_o,
  output logic [E-1:0] fall_o
);

  logic [W-1:0] chain_q [SYNC_N];
  logic [E-1:0] prev_q;

  // Shift the raw pins through the metastability chain.
  always_ff @(posedge clk) begin
    chain_q[0] <= d_i;
    for (int i = 1; i < SYNC_N; i++) begin
      chain_q[i] <= chain_q[i-1];
    end
  end

  // Remember the previous synchronised level of the edge-tracked bits.
  always_ff @(posedge clk) begin
    prev_q <= chain_q[SYNC_N-1][E-1:0];
  end

  assign lvl_o  = chain_q[SYNC_N-1];
  assign rise_o = chain_q[SYNC_N-1][E-1:0] & ~prev_q;
  assign fall_o = ~chain_q[SYNC_N-1][E-1:0] & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI responder running entirely on clk: SCLK/LOAD/MOSI are synchronised,
// frames are delimited by LOAD low, data moves MSB first.
// Optional macro SPI_SLV_FRAME_ERR_EN adds frame_err and an overflow bit.
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SYNC_N = SYNC_N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_sync_if.slave bus_io
);

  localparam int             CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  // Synchronised pins: bit0 SCLK, bit1 LOAD (both with edges), bit2 MOSI.
  logic [2:0] pin_lvl_s;
  logic [1:0] pin_rise_s;
  logic [1:0] pin_fall_s;

  spi_slave_sync_sync #(
    .SYNC_N (SYNC_N),
    .W      (3),
    .E      (2)
  ) u_sync (
    .clk    (clk),
    .d_i    ({bus_io.MOSI, bus_io.LOAD, bus_io.SCLK}),
    .lvl_o  (pin_lvl_s),
    .rise_o (pin_rise_s),
    .fall_o (pin_fall_s)
  );

  logic sclk_lvl_s, load_lvl_s, mosi_s;
  logic sclk_rise_s, sclk_fall_s, load_rise_s, load_fall_s;

  assign sclk_lvl_s  = pin_lvl_s[0];
  assign load_lvl_s  = pin_lvl_s[1];
  assign mosi_s      = pin_lvl_s[2];
  assign sclk_rise_s = pin_rise_s[0];
  assign sclk_fall_s = pin_fall_s[0];
  assign load_rise_s = pin_rise_s[1];
  assign load_fall_s = pin_fall_s[1];

  state_e              state_q, state_d;
  logic                armed_q;
  logic                pend_q;
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                miso_q;
  logic                tx_ack_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                busy_q;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic                ovf_q;
  logic                frame_err_q;
`endif

  // A frame may start once the bus has been seen idle since reset; a LOAD
  // fall that arrived during DONE is remembered in pend_q.
  logic start_req_s;
  assign start_req_s = armed_q & (load_fall_s | pend_q);

  logic start_s, sample_s, shift_s, done_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (load_rise_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes; SCLK edges are honoured in SHIFT even on
  // the cycle LOAD rises, so that edge lands before the frame closes.
  always_comb begin
    start_s  = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    done_s   = 1'b0;
    case (state_q)
      ST_IDLE:  start_s = start_req_s;
      ST_SHIFT: begin
        sample_s = sclk_rise_s;
        shift_s  = sclk_fall_s;
      end
      ST_DONE:  done_s = 1'b1;
      default: begin
        start_s  = 1'b0;
        sample_s = 1'b0;
        shift_s  = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  // Arm after reset only once LOAD is high with SCLK idle, so the tail of
  // a frame interrupted by reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else if (load_lvl_s && !sclk_lvl_s) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_q;
    end
  end

  // Hold a LOAD fall seen during DONE until IDLE can act on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (start_s) begin
      pend_q <= 1'b0;
    end else if ((state_q == ST_DONE) && load_fall_s) begin
      pend_q <= 1'b1;
    end else begin
      pend_q <= pend_q;
    end
  end

  // Shift registers, bit counter and registered host/pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_ack_q   <= start_s;
      rx_valid_q <= done_s && (bit_cnt_q == CNT_FULL);
      if (start_s) begin
        tx_sr_q   <= bus_io.tx_data;
        miso_q    <= bus_io.tx_data[DATA_W-1];
        bit_cnt_q <= '0;
        busy_q    <= 1'b1;
      end else if (done_s) begin
        miso_q <= 1'b0;
        busy_q <= 1'b0;
        if (bit_cnt_q == CNT_FULL) begin
          rx_data_q <= rx_sr_q;
        end else begin
          rx_data_q <= rx_data_q;
        end
      end else begin
        if (sample_s) begin
          rx_sr_q <= {rx_sr_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q != CNT_FULL) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else begin
            bit_cnt_q <= bit_cnt_q;
          end
        end else begin
          rx_sr_q <= rx_sr_q;
        end
        if (shift_s) begin
          tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
          miso_q  <= tx_sr_q[DATA_W-2];
        end else begin
          tx_sr_q <= tx_sr_q;
        end
      end
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  // Sticky flag for more SCLK rises than the saturating counter can show,
  // and the DONE-time error strobe for any inexact frame length.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= done_s && ((bit_cnt_q != CNT_FULL) || ovf_q);
      if (start_s) begin
        ovf_q <= 1'b0;
      end else if (sample_s && (bit_cnt_q == CNT_FULL)) begin
        ovf_q <= 1'b1;
      end else begin
        ovf_q <= ovf_q;
      end
    end
  end

  assign bus_io.frame_err = frame_err_q;
`endif

  assign bus_io.MISO     = miso_q;
  assign bus_io.tx_ack   = tx_ack_q;
  assign bus_io.rx_data  = rx_data_q;
  assign bus_io.rx_valid = rx_valid_q;
  assign bus_io.busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: a behavioural SPI master at clk/8,
// expected words queued at stimulus time, popped by a negedge monitor.
// Build with SPI_SLV_FRAME_ERR_EN defined to also check frame_err.
module tb_spi_slave_sync;

  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   ack_cnt    = 0;

  logic [DW-1:0] exp_rx_q [$];
  logic [DW-1:0] ref_rx;
`ifdef SPI_SLV_FRAME_ERR_EN
  int            err_q [$];
`endif

  spi_slave_sync_if #(.DATA_W(DW)) bus ();

  spi_slave_sync #(.DATA_W(DW), .SYNC_N(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: count tx_ack pulses, pop and compare on every rx_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_ack) ack_cnt++;
      if (bus.rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rx_unexpected: actual strobe with rx_data=%0h required no strobe", bus.rx_data);
        end else begin
          check("rx_data", 32'(bus.rx_data), 32'(exp_rx_q.pop_front()));
        end
      end
`ifdef SPI_SLV_FRAME_ERR_EN
      if (bus.frame_err) begin
        if (err_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL frame_err_unexpected: actual=1 required=0");
        end else begin
          check("frame_err", 32'(bus.frame_err), 32'(err_q.pop_front()));
        end
      end
`endif
    end
  end

  // One frame of nbits SCLK pulses; mosi is sent MSB first from bit nbits-1.
  task automatic run_frame(input logic [DW-1:0] tx, input int nbits,
                           input logic [15:0] mosi, input bit chg_tx, input int gap);
    int          ack0;
    logic [15:0] cap;
    logic [15:0] exp_cap;
    logic        exp_bit;
    ack0    = ack_cnt;
    cap     = 16'd0;
    exp_cap = 16'd0;
    bus.tx_data = tx;
    bus.LOAD    = 1'b0;
    bus.MOSI    = mosi[nbits-1];
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < DW) exp_bit = tx[DW-1-i];
      else        exp_bit = 1'b0;
      cap     = {cap[14:0], bus.MISO};
      exp_cap = {exp_cap[14:0], exp_bit};
      if (i == 0) check("busy_in_frame", 32'(bus.busy), 32'd1);
      bus.SCLK = 1'b1;
      if (chg_tx && i == 0) bus.tx_data = ~tx;
      tick(4);
      bus.SCLK = 1'b0;
      if (i + 1 < nbits) bus.MOSI = mosi[nbits-2-i];
      tick(4);
    end
    bus.LOAD = 1'b1;
    if (nbits >= DW) begin
      ref_rx = mosi[DW-1:0];
      exp_rx_q.push_back(ref_rx);
    end
`ifdef SPI_SLV_FRAME_ERR_EN
    if (nbits != DW) err_q.push_back(1);
`endif
    tick(gap);
    check("miso_bits", 32'(cap), 32'(exp_cap));
    check("tx_ack_count", 32'(ack_cnt - ack0), 32'd1);
    check("rx_pending", 32'(exp_rx_q.size()), 32'd0);
    check("rx_data_held", 32'(bus.rx_data), 32'(ref_rx));
`ifdef SPI_SLV_FRAME_ERR_EN
    check("frame_err_pending", 32'(err_q.size()), 32'd0);
`endif
  endtask

  initial begin
    int ack0;
    int nb;
    rst         = 1'b1;
    bus.SCLK    = 1'b0;
    bus.LOAD    = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_data = '0;
    ref_rx      = '0;
    tick(6);
    check("rst_miso", 32'(bus.MISO), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_tx_ack", 32'(bus.tx_ack), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    tick(6);

    // Reference frame from the datasheet example.
    run_frame(9'b111011011, 9, 16'h017A, 1'b0, 10);
    // tx_data changed mid-frame must not disturb MISO.
    run_frame(9'h0A5, 9, 16'h0133, 1'b1, 10);
    // Short frame: rx_data held, no strobe.
    run_frame(9'h1FF, 5, 16'h0015, 1'b0, 10);
    // Back-to-back frames with LOAD high for one SCLK period.
    run_frame(9'h123, 9, 16'h00C9, 1'b0, 8);
    run_frame(9'h0F0, 9, 16'h0156, 1'b0, 8);
    // Long frame: last nine bits kept, MISO zero after the word.
    run_frame(9'h155, 11, 16'h05A7, 1'b0, 10);

    // Reset after four bits, then the rest of that frame is ignored.
    bus.tx_data = 9'h1C3;
    bus.LOAD    = 1'b0;
    bus.MOSI    = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      bus.SCLK = 1'b1; tick(4);
      bus.SCLK = 1'b0; tick(4);
    end
    rst = 1'b1;
    tick(1);
    check("midrst_miso", 32'(bus.MISO), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("midrst_tx_ack", 32'(bus.tx_ack), 32'd0);
    check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    rst    = 1'b0;
    ref_rx = '0;
    for (int i = 0; i < 5; i++) begin
      bus.SCLK = 1'b1; tick(4);
      bus.SCLK = 1'b0; tick(4);
    end
    check("after_rst_busy", 32'(bus.busy), 32'd0);
    check("after_rst_miso", 32'(bus.MISO), 32'd0);
    bus.LOAD = 1'b1;
    tick(8);
    run_frame(9'h0B6, 9, 16'h0069, 1'b0, 10);

    // SCLK toggling while LOAD is high is ignored.
    ack0 = ack_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.MOSI = 1'($urandom_range(0, 1));
      bus.SCLK = 1'b1; tick(4);
      bus.SCLK = 1'b0; tick(4);
      check("idle_miso", 32'(bus.MISO), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end
    check("idle_tx_ack", 32'(ack_cnt - ack0), 32'd0);
    check("idle_rx_data", 32'(bus.rx_data), 32'(ref_rx));

    // Randomised frames, mostly exact length.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) nb = int'($urandom_range(3, 12));
      else                           nb = DW;
      run_frame(9'($urandom), nb, 16'($urandom), 1'($urandom_range(0, 1)), 10);
    end

    tick(10);
    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
